imem_fetch_unit: RTL and testbench

- Instruction-fetch initiator that drives the read address of the combinational instruction memory and receives its instruction word.
- Sits between imem and the decode stage.
- Maintains the fetch PC and buffers fetched {pc, instruction} pairs in a small FIFO.
- Presents the FIFO head to decode with a valid/ready handshake; supports PC redirects from branches and jumps.

---
 rtl/imem_fetch_unit.sv | 95 +++++++++
 tb/tb_imem_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
//   Instruction-fetch initiator. Drives the read address of a combinational
//   instruction memory from the fetch PC, captures the returned word, and
//   buffers {pc, instruction} pairs in a small prefetch FIFO. The FIFO head
//   is offered to decode through a valid/ready handshake. Branch/jump
//   redirects flush the FIFO and reload the fetch PC.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   fetch_en       in   1   allow new fetches into the FIFO
//   iaddr          out  32  instruction address to imem (= fetch PC)
//   idata          in   32  instruction word from imem (combinational)
//   redirect_valid in   1   branch/jump redirect request
//   redirect_pc    in   32  redirect target (low two bits ignored)
//   inst_valid     out  1   FIFO head valid
//   inst_ready     in   1   decode accepts the head
//   inst_data      out  32  instruction at FIFO head
//   inst_pc        out  32  PC of instruction at FIFO head
// -----------------------------------------------------------------------------
module imem_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;

  assign iaddr      = pc;
  assign inst_valid = (count != '0);
  assign inst_data  = data_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];

  assign pop  = inst_valid & inst_ready;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign push = fetch_en & ~redirect_valid & ((count < CNT_W'(DEPTH)) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush wins over all bookkeeping; a pop this cycle is simply dropped
      // along with the rest of the buffered entries.
      pc     <= {redirect_pc[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= pc;
        data_mem[wr_ptr] <= idata;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        pc               <= pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int tests_run;
  int tests_failed;

  // Expected fetch PC and scoreboard of PCs expected at the FIFO head, in order.
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];

  imem_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .iaddr          (iaddr),
    .idata          (idata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // imem: the word at byte address 4n holds the value n.
  assign idata = {2'b00, iaddr[31:2]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs. Head checks happen
  // before the edge; the scoreboard advances on the edge; iaddr checked after.
  task automatic step(input string tag);
    logic do_pop, do_push;
    chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk({tag, ".pc"},   inst_pc,   exp_q[0]);
      chk({tag, ".data"}, inst_data, exp_q[0] >> 2);
    end
    do_pop  = (exp_q.size() != 0) && inst_ready;
    do_push = fetch_en && !redirect_valid && ((exp_q.size() < 2) || do_pop);
    @(posedge clk);
    if (redirect_valid) begin
      exp_q.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
    #1;
    chk({tag, ".iaddr"}, iaddr, exp_pc);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    exp_pc         = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, inst_valid}, 32'd0);
    chk("rst.data",  inst_data, 32'd0);
    chk("rst.pc",    inst_pc,   32'd0);
    chk("rst.iaddr", iaddr,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stream: one instruction per cycle
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) step("stream");

    // Asynchronous reset between edges, then fetch_en gating
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, inst_valid}, 32'd0);
    chk("arst.iaddr", iaddr, 32'd0);
    exp_q.delete();
    exp_pc   = 32'h0;
    fetch_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step("gated");
    chk("gated.iaddr_hold", iaddr, 32'd0);

    // Backpressure: fills to 2, PC stops at 8, head held at PC 0
    fetch_en   = 1'b1;
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) step("bp");
    chk("bp.iaddr_stop", iaddr, 32'd8);
    chk("bp.head_pc",    inst_pc, 32'd0);
    chk("bp.head_data",  inst_data, 32'd0);

    // Full with simultaneous pop: PC 0 out, PC 8 in
    inst_ready = 1'b1;
    step("fullpop");
    chk("fullpop.iaddr", iaddr, 32'd12);
    chk("fullpop.head",  inst_pc, 32'd4);
    inst_ready = 1'b0;
    step("hold");

    // Redirect while full to unaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step("redir");
    chk("redir.iaddr", iaddr, 32'h0000_0100);
    chk("redir.bubble", {31'd0, inst_valid}, 32'd0);
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    step("redir1");
    chk("redir.tgt_pc",   inst_pc,   32'h0000_0100);
    chk("redir.tgt_data", inst_data, 32'h0000_0040);
    for (int i = 0; i < 3; i++) step("redir_stream");

    // Wrap-around through the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step("wrap_redir");
    redirect_valid = 1'b0;
    step("wrap0");
    chk("wrap.pc0", inst_pc, 32'hFFFF_FFF8);
    step("wrap1");
    chk("wrap.pc1", inst_pc, 32'hFFFF_FFFC);
    step("wrap2");
    chk("wrap.pc2", inst_pc, 32'h0000_0000);
    for (int i = 0; i < 3; i++) step("wrap_stream");

    // Redirect with a pop presented in the same cycle
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step("redir_pop");
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) step("post");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
